// File: rtl/cursor_select.sv
// cursor_select: input stage in front of the cat-trap game FSM.
// Synchronizes and debounces the five board buttons, keeps a wrapping
// cursor over the board and issues valid/ready placement requests.
// Optional feature macro: CURSOR_AUTO_REPEAT_EN (auto-repeat of held
// direction buttons every REPEAT_CYCLES).
module cursor_select #(
  parameter int ROWS            = 6,
  parameter int COLS            = 7,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       Up_b,
  input  logic       Down_b,
  input  logic       Left_b,
  input  logic       Right_b,
  input  logic       Center_b,
  input  logic       cell_blocked,
  input  logic       place_ready,
  output logic       place_valid,
  output logic [3:0] place_row,
  output logic [3:0] place_col,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       place_reject
);

  localparam int NBTN       = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [3:0] COL_LAST = 4'(COLS - 1);

  typedef enum logic [1:0] {
    DEB_IDLE,
    DEB_CONFIRM_HI,
    DEB_HELD,
    DEB_CONFIRM_LO
  } deb_state_e;

  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] press_q;
  deb_state_e      state_q [NBTN];
  logic [CNT_W-1:0] cnt_q  [NBTN];

  logic [3:0] step;

  logic       valid_q, valid_d;
  logic [3:0] prow_q, prow_d;
  logic [3:0] pcol_q, pcol_d;
  logic [3:0] crow_q, crow_d;
  logic [3:0] ccol_q, ccol_d;
  logic       reject_q, reject_d;

  assign raw = {Center_b, Right_b, Left_b, Down_b, Up_b};

  // Two-flop synchronizers feeding one debounce FSM per button; a press
  // pulse fires once when a high level has been confirmed long enough.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= DEB_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < NBTN; i++) begin
        press_q[i] <= 1'b0;
        case (state_q[i])
          DEB_IDLE: begin
            if (sync2_q[i]) begin
              state_q[i] <= DEB_CONFIRM_HI;
              cnt_q[i]   <= '0;
            end
          end
          DEB_CONFIRM_HI: begin
            if (!sync2_q[i]) begin
              state_q[i] <= DEB_IDLE;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= DEB_HELD;
              press_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          DEB_HELD: begin
            if (!sync2_q[i]) begin
              state_q[i] <= DEB_CONFIRM_LO;
              cnt_q[i]   <= '0;
            end
          end
          DEB_CONFIRM_LO: begin
            if (sync2_q[i]) begin
              state_q[i] <= DEB_HELD;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= DEB_IDLE;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_q[i] <= DEB_IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

`ifdef CURSOR_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rptCnt_q [4];
  logic [3:0]       rpt_q;

  // While a direction button stays held, emit an extra step pulse every
  // REPEAT_CYCLES; the count restarts whenever the button leaves HELD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rpt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        rptCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        rpt_q[i] <= 1'b0;
        if (state_q[i] == DEB_HELD) begin
          if (rptCnt_q[i] == RPT_LAST) begin
            rpt_q[i]    <= 1'b1;
            rptCnt_q[i] <= '0;
          end else begin
            rptCnt_q[i] <= rptCnt_q[i] + 1'b1;
          end
        end else begin
          rptCnt_q[i] <= '0;
        end
      end
    end
  end

  assign step = press_q[3:0] | rpt_q;
`else
  assign step = press_q[3:0];
`endif

  // Cursor movement, placement request and handshake; only one action per
  // cycle, Center first, and all presses are dropped while a request waits.
  always_comb begin
    valid_d  = valid_q;
    prow_d   = prow_q;
    pcol_d   = pcol_q;
    crow_d   = crow_q;
    ccol_d   = ccol_q;
    reject_d = 1'b0;
    if (valid_q) begin
      if (!enable || place_ready) begin
        valid_d = 1'b0;
      end
    end else if (enable) begin
      if (press_q[BTN_CENTER]) begin
        if (cell_blocked) begin
          reject_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          prow_d  = crow_q;
          pcol_d  = ccol_q;
        end
      end else if (step[BTN_UP]) begin
        crow_d = (crow_q == 4'd0) ? ROW_LAST : crow_q - 4'd1;
      end else if (step[BTN_DOWN]) begin
        crow_d = (crow_q == ROW_LAST) ? 4'd0 : crow_q + 4'd1;
      end else if (step[BTN_LEFT]) begin
        ccol_d = (ccol_q == 4'd0) ? COL_LAST : ccol_q - 4'd1;
      end else if (step[BTN_RIGHT]) begin
        ccol_d = (ccol_q == COL_LAST) ? 4'd0 : ccol_q + 4'd1;
      end
    end
  end

  // Register cursor, request and reject state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q  <= 1'b0;
      prow_q   <= '0;
      pcol_q   <= '0;
      crow_q   <= '0;
      ccol_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      prow_q   <= prow_d;
      pcol_q   <= pcol_d;
      crow_q   <= crow_d;
      ccol_q   <= ccol_d;
      reject_q <= reject_d;
    end
  end

  assign place_valid  = valid_q;
  assign place_row    = prow_q;
  assign place_col    = pcol_q;
  assign cursor_row   = crow_q;
  assign cursor_col   = ccol_q;
  assign place_reject = reject_q;

endmodule
